// File: rtl/fg_pkg.sv
// Shared types and default widths for the flow generator blocks.
package fg_pkg;

    localparam int FG_DEST_WIDTH      = 8;
    localparam int FG_BURST_LEN_WIDTH = 32;
    localparam int FG_PERIOD_WIDTH    = 32;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_OUTPUT = 1'b1
    } fg_state_e;

    // Flow entry at the default widths; parameterised users build their own.
    typedef struct packed {
        logic                          en;
        logic [FG_DEST_WIDTH-1:0]      dest;
        logic [FG_BURST_LEN_WIDTH-1:0] burst_len;
        logic [FG_PERIOD_WIDTH-1:0]    period;
    } fg_flow_cfg_t;

endpackage

// File: rtl/fg_burst_scheduler_if.sv
// Burst descriptor stream (valid/ready, dest, burst length, flow index).
interface fg_burst_scheduler_if
    import fg_pkg::*;
#(
    parameter int DEST_WIDTH       = FG_DEST_WIDTH,
    parameter int FLOW_INDEX_WIDTH = 2
);
    logic                          output_bd_valid;
    logic                          output_bd_ready;
    logic [DEST_WIDTH-1:0]         output_bd_dest;
    logic [FG_BURST_LEN_WIDTH-1:0] output_bd_burst_len;
    logic [FLOW_INDEX_WIDTH-1:0]   output_bd_flow;

    modport master (
        output output_bd_valid,
        output output_bd_dest,
        output output_bd_burst_len,
        output output_bd_flow,
        input  output_bd_ready
    );

    modport slave (
        input  output_bd_valid,
        input  output_bd_dest,
        input  output_bd_burst_len,
        input  output_bd_flow,
        output output_bd_ready
    );
endinterface

// File: rtl/fg_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap.
module fg_rr_arbiter #(
    parameter int REQ_COUNT = 4,
    parameter int IDX_WIDTH = $clog2(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] gnt,
    output logic                 gnt_valid
);
    logic [IDX_WIDTH-1:0] idx;

    // REQ_COUNT is a power of two, so the index wraps by truncation.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            idx = ptr + IDX_WIDTH'(i);
            if (!gnt_valid && req[idx]) begin
                gnt       = idx;
                gnt_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fg_burst_scheduler.sv
// Periodic multi-flow burst descriptor scheduler with round-robin output arbitration.
// Optional counters: define FG_BURST_SCHEDULER_STATS_EN.
module fg_burst_scheduler
    import fg_pkg::*;
#(
    parameter int FLOW_COUNT       = 4,
    parameter int FLOW_INDEX_WIDTH = $clog2(FLOW_COUNT),
    parameter int DEST_WIDTH       = FG_DEST_WIDTH,
    parameter int PERIOD_WIDTH     = FG_PERIOD_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          cfg_wr_en,
    input  logic [FLOW_INDEX_WIDTH-1:0]   cfg_index,
    input  logic                          cfg_flow_en,
    input  logic [DEST_WIDTH-1:0]         cfg_dest,
    input  logic [FG_BURST_LEN_WIDTH-1:0] cfg_burst_len,
    input  logic [PERIOD_WIDTH-1:0]       cfg_period,
    fg_burst_scheduler_if.master          bd,
    output logic                          busy
`ifdef FG_BURST_SCHEDULER_STATS_EN
    ,
    output logic [31:0]                   status_issued_count,
    output logic [31:0]                   status_missed_count
`endif
);
    typedef struct packed {
        logic                          en;
        logic [DEST_WIDTH-1:0]         dest;
        logic [FG_BURST_LEN_WIDTH-1:0] burst_len;
        logic [PERIOD_WIDTH-1:0]       period;
    } flow_cfg_t;

    flow_cfg_t                     cfg_q   [FLOW_COUNT];
    flow_cfg_t                     cfg_d   [FLOW_COUNT];
    logic [PERIOD_WIDTH-1:0]       timer_q [FLOW_COUNT];
    logic [PERIOD_WIDTH-1:0]       timer_d [FLOW_COUNT];
    logic [FLOW_COUNT-1:0]         pending_q, pending_d;
    logic [FLOW_COUNT-1:0]         fire, missed;
    logic [FLOW_INDEX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [FLOW_INDEX_WIDTH-1:0]   gnt;
    logic                          gnt_valid;
    fg_state_e                     state_q, state_d;
    logic                          valid_q, valid_d;
    logic [DEST_WIDTH-1:0]         dest_q, dest_d;
    logic [FG_BURST_LEN_WIDTH-1:0] len_q, len_d;
    logic [FLOW_INDEX_WIDTH-1:0]   flow_q, flow_d;
    logic                          accept;

    fg_rr_arbiter #(
        .REQ_COUNT (FLOW_COUNT),
        .IDX_WIDTH (FLOW_INDEX_WIDTH)
    ) u_arb (
        .req       (pending_q),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    assign accept = valid_q && bd.output_bd_ready;

    always_comb begin
        cfg_d     = cfg_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        fire      = '0;
        missed    = '0;
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        valid_d   = valid_q;
        dest_d    = dest_q;
        len_d     = len_q;
        flow_d    = flow_q;

        for (int f = 0; f < FLOW_COUNT; f++) begin
            fire[f] = enable && cfg_q[f].en && (timer_q[f] == '0);
            if (enable && cfg_q[f].en) begin
                timer_d[f] = fire[f] ? cfg_q[f].period : timer_q[f] - PERIOD_WIDTH'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && gnt_valid) begin
                    dest_d         = cfg_q[gnt].dest;
                    len_d          = cfg_q[gnt].burst_len;
                    flow_d         = gnt;
                    pending_d[gnt] = 1'b0;
                    valid_d        = 1'b1;
                    state_d        = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (accept) begin
                    valid_d  = 1'b0;
                    rr_ptr_d = flow_q + FLOW_INDEX_WIDTH'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Priority: grant clear < timer fire < config disable.
        for (int f = 0; f < FLOW_COUNT; f++) begin
            if (fire[f]) begin
                missed[f]    = pending_q[f];
                pending_d[f] = 1'b1;
            end
        end

        if (cfg_wr_en) begin
            if (cfg_flow_en && !cfg_q[cfg_index].en) begin
                timer_d[cfg_index] = '0;
            end
            if (!cfg_flow_en) begin
                timer_d[cfg_index]   = timer_q[cfg_index];
                pending_d[cfg_index] = 1'b0;
                missed[cfg_index]    = 1'b0;
            end
            cfg_d[cfg_index] = '{en: cfg_flow_en, dest: cfg_dest,
                                 burst_len: cfg_burst_len, period: cfg_period};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            pending_q <= '0;
            valid_q   <= 1'b0;
            dest_q    <= '0;
            len_q     <= '0;
            flow_q    <= '0;
            for (int f = 0; f < FLOW_COUNT; f++) begin
                cfg_q[f]   <= '0;
                timer_q[f] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            dest_q    <= dest_d;
            len_q     <= len_d;
            flow_q    <= flow_d;
            cfg_q     <= cfg_d;
            timer_q   <= timer_d;
        end
    end

    assign bd.output_bd_valid     = valid_q;
    assign bd.output_bd_dest      = dest_q;
    assign bd.output_bd_burst_len = len_q;
    assign bd.output_bd_flow      = flow_q;
    assign busy                   = valid_q || (|pending_q);

`ifdef FG_BURST_SCHEDULER_STATS_EN
    logic [31:0] issued_q, issued_d;
    logic [31:0] missed_cnt_q, missed_cnt_d;

    always_comb begin
        issued_d     = issued_q;
        missed_cnt_d = missed_cnt_q;
        if (accept) begin
            issued_d = issued_q + 32'd1;
        end
        if (|missed) begin
            missed_cnt_d = missed_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q     <= '0;
            missed_cnt_q <= '0;
        end else begin
            issued_q     <= issued_d;
            missed_cnt_q <= missed_cnt_d;
        end
    end

    assign status_issued_count = issued_q;
    assign status_missed_count = missed_cnt_q;
`endif
endmodule

// File: tb/tb_fg_burst_scheduler.sv
// Scoreboard bench for fg_burst_scheduler: expected descriptors queued at stimulus time.
module tb_fg_burst_scheduler;
    import fg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        cfg_wr_en;
    logic [1:0]  cfg_index;
    logic        cfg_flow_en;
    logic [7:0]  cfg_dest;
    logic [31:0] cfg_burst_len;
    logic [31:0] cfg_period;
    logic        busy;
`ifdef FG_BURST_SCHEDULER_STATS_EN
    logic [31:0] status_issued_count;
    logic [31:0] status_missed_count;
`endif

    fg_burst_scheduler_if #(.DEST_WIDTH(8), .FLOW_INDEX_WIDTH(2)) bd ();

    fg_burst_scheduler #(.FLOW_COUNT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_index     (cfg_index),
        .cfg_flow_en   (cfg_flow_en),
        .cfg_dest      (cfg_dest),
        .cfg_burst_len (cfg_burst_len),
        .cfg_period    (cfg_period),
        .bd            (bd.master),
        .busy          (busy)
`ifdef FG_BURST_SCHEDULER_STATS_EN
        ,
        .status_issued_count (status_issued_count),
        .status_missed_count (status_missed_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  dest;
        logic [31:0] len;
        logic [1:0]  flow;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [31:0] l, input logic [1:0] f);
        exp_t e;
        e.dest = d;
        e.len  = l;
        e.flow = f;
        exp_q.push_back(e);
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic en, input logic [7:0] d,
                             input logic [31:0] l, input logic [31:0] p);
        cfg_index     = idx;
        cfg_flow_en   = en;
        cfg_dest      = d;
        cfg_burst_len = l;
        cfg_period    = p;
        cfg_wr_en     = 1'b1;
        tick(1);
        cfg_wr_en     = 1'b0;
    endtask

    task automatic wait_acc(input string tag, input int n, input int budget);
        int k = 0;
        while (acc_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check_eq(tag, acc_cyc.size(), n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, bd.output_bd_valid, 0);
        check_eq({tag, "_dest"}, bd.output_bd_dest, 0);
        check_eq({tag, "_len"}, bd.output_bd_burst_len, 0);
        check_eq({tag, "_flow"}, bd.output_bd_flow, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        enable = 1'b0;
        bd.output_bd_ready = 1'b0;
        tick(2);
        check_idle_outputs(tag);
        check_eq({tag, "_sb_left"}, exp_q.size(), 0);
        exp_q.delete();
        acc_cyc.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        cfg_wr_en = 1'b0;
        cfg_index = '0;
        cfg_flow_en = 1'b0;
        cfg_dest = '0;
        cfg_burst_len = '0;
        cfg_period = '0;
        bd.output_bd_ready = 1'b0;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                if (rst_n && bd.output_bd_valid) begin
                    if (exp_q.size() != 0) begin
                        check_eq("bd_dest", bd.output_bd_dest, exp_q[0].dest);
                        check_eq("bd_len", bd.output_bd_burst_len, exp_q[0].len);
                        check_eq("bd_flow", bd.output_bd_flow, exp_q[0].flow);
                    end
                    if (bd.output_bd_ready) begin
                        check_eq("bd_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        acc_cyc.push_back(cyc);
                    end
                end
            end
            begin
                #100000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        tick(2);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(1);

        // Single flow, period 9: one descriptor every 10 cycles.
        enable = 1'b1;
        bd.output_bd_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(8'd5, 32'd1000, 2'd0);
        cfg_write(2'd0, 1'b1, 8'd5, 32'd1000, 32'd9);
        wait_acc("t1_count", 4, 100);
        bd.output_bd_ready = 1'b0;
        for (int i = 1; i < acc_cyc.size(); i++)
            check_eq("t1_spacing", acc_cyc[i] - acc_cyc[i-1], 10);
        do_reset("t1_rst");

        // Four flows, period 0: strict rotation, one descriptor per 2 cycles.
        bd.output_bd_ready = 1'b1;
        for (int f = 0; f < 4; f++)
            cfg_write(2'(f), 1'b1, 8'(8'd10 + f), 32'(100 + f), 32'd0);
        for (int r = 0; r < 2; r++)
            for (int f = 0; f < 4; f++) push_exp(8'(8'd10 + f), 32'(100 + f), 2'(f));
        enable = 1'b1;
        wait_acc("t2_count", 8, 60);
        bd.output_bd_ready = 1'b0;
        for (int i = 1; i < acc_cyc.size(); i++)
            check_eq("t2_spacing", acc_cyc[i] - acc_cyc[i-1], 2);
        do_reset("t2_rst");

        // Back-pressure: held descriptor, missed fires collapse into one more.
        enable = 1'b1;
        push_exp(8'h21, 32'd33, 2'd1);
        push_exp(8'h21, 32'd33, 2'd1);
        cfg_write(2'd1, 1'b1, 8'h21, 32'd33, 32'd3);
        tick(20);
        check_eq("t3_hold_valid", bd.output_bd_valid, 1);
        check_eq("t3_hold_busy", busy, 1);
        check_eq("t3_hold_noacc", acc_cyc.size(), 0);
`ifdef FG_BURST_SCHEDULER_STATS_EN
        check_eq("t3_missed_nz", status_missed_count != 0, 1);
`endif
        bd.output_bd_ready = 1'b1;
        tick(4);
        bd.output_bd_ready = 1'b0;
        check_eq("t3_count", acc_cyc.size(), 2);
`ifdef FG_BURST_SCHEDULER_STATS_EN
        check_eq("t3_issued", status_issued_count, 2);
`endif
        do_reset("t3_rst");

        // Disable a pending flow before it is granted, then re-enable it.
        cfg_write(2'd0, 1'b1, 8'h40, 32'd64, 32'd0);
        cfg_write(2'd2, 1'b1, 8'h42, 32'd66, 32'd0);
        push_exp(8'h40, 32'd64, 2'd0);
        enable = 1'b1;
        tick(3);
        check_eq("t4_held", bd.output_bd_valid, 1);
        cfg_write(2'd2, 1'b0, 8'h42, 32'd66, 32'd0);
        cfg_write(2'd0, 1'b0, 8'h40, 32'd64, 32'd0);
        bd.output_bd_ready = 1'b1;
        tick(6);
        check_eq("t4_count", acc_cyc.size(), 1);
        check_eq("t4_busy", busy, 0);
        bd.output_bd_ready = 1'b0;
        push_exp(8'h42, 32'd66, 2'd2);
        cfg_write(2'd2, 1'b1, 8'h42, 32'd66, 32'd0);
        check_eq("t4_reen_c0", bd.output_bd_valid, 0);
        tick(1);
        check_eq("t4_reen_c1", bd.output_bd_valid, 0);
        tick(1);
        check_eq("t4_reen_c2", bd.output_bd_valid, 1);
        cfg_write(2'd2, 1'b0, 8'h42, 32'd66, 32'd0);
        bd.output_bd_ready = 1'b1;
        tick(4);
        check_eq("t4_count2", acc_cyc.size(), 2);
        do_reset("t4_rst");

        // Config write while a descriptor is held does not disturb it.
        cfg_write(2'd0, 1'b1, 8'd7, 32'd70, 32'd0);
        push_exp(8'd7, 32'd70, 2'd0);
        push_exp(8'd9, 32'd90, 2'd0);
        enable = 1'b1;
        tick(3);
        cfg_write(2'd0, 1'b1, 8'd9, 32'd90, 32'd0);
        tick(2);
        check_eq("t5_dest_held", bd.output_bd_dest, 7);
        check_eq("t5_len_held", bd.output_bd_burst_len, 70);
        bd.output_bd_ready = 1'b1;
        wait_acc("t5_count", 2, 20);
        bd.output_bd_ready = 1'b0;
        tick(2);
        check_eq("t6_pre_valid", bd.output_bd_valid, 1);

        // Asynchronous reset while valid is high.
        rst_n = 1'b0;
        #2;
        check_eq("t6_async_valid", bd.output_bd_valid, 0);
        check_eq("t6_async_dest", bd.output_bd_dest, 0);
        tick(2);
        check_eq("t6_sb_left", exp_q.size(), 0);
        exp_q.delete();
        acc_cyc.delete();
        rst_n = 1'b1;
        enable = 1'b1;
        bd.output_bd_ready = 1'b1;
        tick(20);
        check_eq("t6_quiet_acc", acc_cyc.size(), 0);
        check_eq("t6_quiet_busy", busy, 0);
        push_exp(8'h33, 32'd51, 2'd3);
        cfg_write(2'd3, 1'b1, 8'h33, 32'd51, 32'd50);
        wait_acc("t6_count", 1, 10);
        tick(5);
        check_eq("t6_sb_left_end", exp_q.size(), 0);
        check_eq("t6_count_end", acc_cyc.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fg_burst_scheduler.md
Name: fg_burst_scheduler

Overview:
- Periodic, multi-flow burst descriptor scheduler for the flow generator.
- Holds FLOW_COUNT flow entries, each with a destination index, burst length, repeat period and enable bit.
- Fires each enabled flow on its own timer and round-robin arbitrates the due flows onto one burst descriptor stream (valid/ready, dest, burst_len).
- The stream drives the IP packet generator's descriptor input.

Parameters:
- FLOW_COUNT, 4, number of flow entries; power of two, at least 2.
- FLOW_INDEX_WIDTH, $clog2(FLOW_COUNT), width of the flow index.
- DEST_WIDTH, 8, width of the destination index carried in descriptors.
- PERIOD_WIDTH, 32, width of the per-flow period timer.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  global run; when low, timers freeze and no new grants are made.
- cfg_wr_en  input  1  write the flow entry addressed by cfg_index.
- cfg_index  input  FLOW_INDEX_WIDTH  flow entry to write.
- cfg_flow_en  input  1  flow enable.
- cfg_dest  input  DEST_WIDTH  destination index for the flow.
- cfg_burst_len  input  32  burst length for the flow.
- cfg_period  input  PERIOD_WIDTH  repeat period P; the flow fires every P+1 enabled cycles.
- output_bd_valid  output  1  descriptor valid.
- output_bd_ready  input  1  descriptor accepted.
- output_bd_dest  output  DEST_WIDTH  descriptor destination.
- output_bd_burst_len  output  32  descriptor burst length.
- output_bd_flow  output  FLOW_INDEX_WIDTH  index of the granted flow.
- busy  output  1  high when output_bd_valid is high or any pending bit is set.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - All flow entries: disabled, dest 0, burst_len 0, period 0.
  - Timers 0, pending bits 0, round-robin pointer 0, state IDLE.
- Timer, per flow, evaluated only when enable=1 and the flow is enabled:
  - If timer==0: set pending[f] and reload timer with period.
  - Otherwise: decrement timer by 1.
  - First fire occurs on the first enabled cycle after the flow is enabled (timer is 0 after enable).
  - Period 0 fires every cycle.
- Missed slot: a fire while pending[f] is already set leaves pending[f]=1. The fire is dropped; there is no queueing.
- Config write (cfg_wr_en=1):
  - Writes all four fields of entry cfg_index.
  - Timer is loaded with 0 on a 0->1 enable transition and left unchanged otherwise.
  - cfg_flow_en=0 clears pending[cfg_index] and freezes the timer.
  - A descriptor already latched on the output is unaffected by any write.
- State machine:
  - IDLE: if enable=1 and any pending bit is set, grant the first pending flow at or after rr_ptr, scanning upward with wrap.
    - Latch dest, burst_len and flow index into the output registers.
    - Clear pending[grant]; assert output_bd_valid on the next cycle; go to OUTPUT.
  - OUTPUT: hold the output registers stable while valid && !ready.
    - On valid && ready: deassert valid, set rr_ptr = grant+1 (wrapping at FLOW_COUNT-1 -> 0), go to IDLE.
- Throughput is at most one descriptor per 2 cycles. Grant-to-valid latency is 1 cycle.
- Simultaneous events:
  - Grant-clear and timer-fire on the same flow in the same cycle: the fire wins, so pending stays 1.
  - Config-disable and timer-fire on the same flow in the same cycle: the disable wins, so pending becomes 0.
- enable dropping during OUTPUT: the current descriptor is still held until accepted. Pending bits are retained.
- Reset asserted mid-transfer: valid drops asynchronously and all state returns to reset values.

Optional Feature:
- Macro: FG_BURST_SCHEDULER_STATS_EN.
- When defined, two extra output ports exist, both cleared by reset and wrapping modulo 2^32:
  - status_issued_count, 32 bits: increments on each accepted descriptor (valid && ready).
  - status_missed_count, 32 bits: increments once per cycle in which at least one missed slot occurs.
- When undefined, neither port nor its counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package fg_pkg holds:
  - Scheduler state encoding (IDLE, OUTPUT).
  - The flow config entry struct (en, dest, burst_len, period).
  - Default widths (DEST_WIDTH, burst length width 32).
- One sub-module, fg_rr_arbiter:
  - Combinational round-robin pick: request vector plus pointer in; grant index and grant-valid out.
  - Reusable by other flow generator blocks.

Test Plan:
- Reset, then configure flow 0 (dest 5, len 1000, period 9), enable=1, ready=1 -> descriptors with dest 5, len 1000, flow 0, spaced exactly 10 cycles apart.
- Flows 0-3 with period 0, ready=1 -> grant order 0,1,2,3,0,... with one descriptor every 2 cycles.
- Flow 1 with period 3, ready held 0 for 20 cycles -> a single descriptor held stable on the output; after ready rises, exactly one more descriptor follows. With STATS_EN, missed_count is greater than 0.
- Disable flow 2 while pending=1 and not granted -> no descriptor is issued for flow 2. Re-enabling it fires on the first enabled cycle.
- Config write to flow 0 while its descriptor is held (valid=1, ready=0) -> output dest and len are unchanged until accepted; the next descriptor carries the new values.
- Assert rst_n=0 while valid=1 -> valid is 0 immediately without waiting for a clock edge; after reset, no descriptor is issued until a flow is re-enabled.
